m_proc_pipe: RTL and testbench

Parametrised 4-stage pipelined RV32I-subset processor: IF, ID, EX, WB. It supersedes the single-cycle add/addi datapath and adds several features:
- synchronous reset;
- sub/and/or/beq;
- a selectable hazard mode (forwarding or interlock);
- taken-branch flush;
- a retire port for the bench;
- a halt flag in place of simulator termination.

Instruction memory is an internal asynchronous ROM loaded hierarchically by the testbench.

---
 rtl/proc_pkg.sv | 60 ++++++
 rtl/m_imem_p.sv | 13 +
 rtl/m_proc_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_m_proc_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the m_proc_pipe RV32I-subset pipeline: encodings, ALU ops,
// stage-register bundles and immediate helpers.
package proc_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;  // add, sub and addi
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluPass
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        is_beq;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
  } exwb_t;

  function automatic logic [31:0] imm_i(logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/m_imem_p.sv
// Asynchronous instruction ROM; contents are written hierarchically by the testbench.
module m_imem_p #(
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic [$clog2(IMEM_WORDS)-1:0] addr,
  output logic [31:0]                   rdata
);

  logic [31:0] mem [IMEM_WORDS] = '{default: '0};

  assign rdata = mem[addr];

endmodule

// File: rtl/m_proc_pipe.sv
// Four-stage IF/ID/EX/WB RV32I-subset pipeline (add/sub/and/or/addi/beq) with selectable
// EX->ID forwarding or interlock, taken-branch flush, retire port and sticky halt.
module m_proc_pipe
  import proc_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter bit          FORWARD    = 1'b1,
  parameter int unsigned HALT_REG   = 30
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_retire,
  output logic [31:0] w_retire_pc,
  output logic [4:0]  w_retire_rd,
  output logic [31:0] w_retire_data,
  output logic        w_halt,
  output logic [15:0] w_stall_cnt
);

  localparam int unsigned AW     = $clog2(IMEM_WORDS);
  localparam logic [4:0]  HaltRd = 5'(HALT_REG);

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exwb_t       exwb_q, exwb_d;
  logic        halt_q, halt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] rf [32];
  logic [31:0] fetch_instr;

  m_imem_p #(
    .IMEM_WORDS(IMEM_WORDS)
  ) m_imem (
    .addr (pc_q[AW+1:2]),
    .rdata(fetch_instr)
  );

  // EX stage
  logic [31:0] op_b, ex_result, br_target;
  logic        br_taken, ex_fwd;

  always_comb begin
    op_b = idex_q.use_imm ? idex_q.imm : idex_q.rs2_val;
    unique case (idex_q.alu_op)
      AluAdd:  ex_result = idex_q.rs1_val + op_b;
      AluSub:  ex_result = idex_q.rs1_val - op_b;
      AluAnd:  ex_result = idex_q.rs1_val & op_b;
      AluOr:   ex_result = idex_q.rs1_val | op_b;
      default: ex_result = op_b;
    endcase
    br_taken  = idex_q.valid && idex_q.is_beq && (idex_q.rs1_val == idex_q.rs2_val);
    br_target = idex_q.pc + idex_q.imm;
    ex_fwd    = idex_q.valid && idex_q.wr_en;
  end

  // ID stage
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  alu_op_e     dec_alu;
  logic        dec_imm, dec_beq, dec_wr, use_rs1, use_rs2;
  logic [31:0] rs1_val, rs2_val;
  logic        wb_we, raw, stall;

  assign opcode = ifid_q.instr[6:0];
  assign rd     = ifid_q.instr[11:7];
  assign funct3 = ifid_q.instr[14:12];
  assign rs1    = ifid_q.instr[19:15];
  assign rs2    = ifid_q.instr[24:20];
  assign funct7 = ifid_q.instr[31:25];
  assign wb_we  = exwb_q.valid && exwb_q.wr_en;

  always_comb begin
    dec_alu = AluPass;
    dec_imm = 1'b0;
    dec_beq = 1'b0;
    dec_wr  = 1'b0;
    unique case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE && funct3 == F3_ADD) begin
          dec_alu = AluAdd;
          dec_wr  = 1'b1;
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          dec_alu = AluSub;
          dec_wr  = 1'b1;
        end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
          dec_alu = AluAnd;
          dec_wr  = 1'b1;
        end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
          dec_alu = AluOr;
          dec_wr  = 1'b1;
        end
      end
      OP_I: begin
        if (funct3 == F3_ADD) begin
          dec_alu = AluAdd;
          dec_imm = 1'b1;
          dec_wr  = 1'b1;
        end
      end
      OP_B: dec_beq = (funct3 == F3_BEQ);
      default: ;
    endcase
    use_rs1 = dec_wr || dec_beq;
    use_rs2 = (dec_wr && !dec_imm) || dec_beq;
  end

  // Operand read: EX forward beats the WB write-through, which beats the array.
  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (wb_we && exwb_q.rd == rs1) rs1_val = exwb_q.data;
    if (wb_we && exwb_q.rd == rs2) rs2_val = exwb_q.data;
    if (FORWARD && ex_fwd && idex_q.rd == rs1) rs1_val = ex_result;
    if (FORWARD && ex_fwd && idex_q.rd == rs2) rs2_val = ex_result;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
    // idex_q.rd is nonzero whenever wr_en is set, so x0 never matches
    raw   = ifid_q.valid && ex_fwd &&
            ((use_rs1 && idex_q.rd == rs1) || (use_rs2 && idex_q.rd == rs2));
    stall = !FORWARD && raw && !br_taken;
  end

  // Next state
  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    idex_d      = '0;
    exwb_d      = '0;
    halt_d      = halt_q || (wb_we && exwb_q.rd == HaltRd);
    stall_cnt_d = stall_cnt_q;

    if (!halt_q) begin
      if (br_taken)    pc_d = br_target;
      else if (!stall) pc_d = pc_q + 32'd4;
    end

    if (br_taken) begin
      ifid_d = '0;
    end else if (!stall) begin
      ifid_d.valid = !halt_q;
      ifid_d.pc    = halt_q ? '0 : pc_q;
      ifid_d.instr = halt_q ? '0 : fetch_instr;
    end

    if (ifid_q.valid && !br_taken && !stall) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = ifid_q.pc;
      idex_d.alu_op  = dec_alu;
      idex_d.use_imm = dec_imm;
      idex_d.is_beq  = dec_beq;
      idex_d.wr_en   = dec_wr && (rd != 5'd0);
      idex_d.rd      = (dec_wr && (rd != 5'd0)) ? rd : 5'd0;
      idex_d.rs1_val = rs1_val;
      idex_d.rs2_val = rs2_val;
      idex_d.imm     = (opcode == OP_B) ? imm_b(ifid_q.instr) : imm_i(ifid_q.instr);
    end

    if (idex_q.valid) begin
      exwb_d.valid = 1'b1;
      exwb_d.pc    = idex_q.pc;
      exwb_d.wr_en = idex_q.wr_en;
      exwb_d.rd    = idex_q.rd;
      exwb_d.data  = idex_q.wr_en ? ex_result : '0;
    end

    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pc_q        <= '0;
      ifid_q      <= '0;
      idex_q      <= '0;
      exwb_q      <= '0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      exwb_q      <= exwb_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[exwb_q.rd] <= exwb_q.data;
    end
  end

  assign w_retire      = exwb_q.valid;
  assign w_retire_pc   = exwb_q.pc;
  assign w_retire_rd   = exwb_q.rd;
  assign w_retire_data = exwb_q.data;
  assign w_halt        = halt_q;
  assign w_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_m_proc_pipe.sv
// Scoreboard bench: runs each program on a forwarding and an interlocking instance and
// compares every retire against hand-derived expectations.
module tb_m_proc_pipe;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  always #5 w_clk = ~w_clk;

  logic        f_ret, s_ret, f_halt, s_halt;
  logic [31:0] f_pc, s_pc, f_data, s_data;
  logic [4:0]  f_rd, s_rd;
  logic [15:0] f_stall, s_stall;

  m_proc_pipe #(.IMEM_WORDS(64), .FORWARD(1'b1), .HALT_REG(30)) dut_f (
    .w_clk(w_clk), .w_rst(w_rst), .w_retire(f_ret), .w_retire_pc(f_pc), .w_retire_rd(f_rd),
    .w_retire_data(f_data), .w_halt(f_halt), .w_stall_cnt(f_stall)
  );

  m_proc_pipe #(.IMEM_WORDS(64), .FORWARD(1'b0), .HALT_REG(30)) dut_s (
    .w_clk(w_clk), .w_rst(w_rst), .w_retire(s_ret), .w_retire_pc(s_pc), .w_retire_rd(s_rd),
    .w_retire_data(s_data), .w_halt(s_halt), .w_stall_cnt(s_stall)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q_f[$];
  exp_t        q_s[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog_end;
  int          halt_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_i(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                        input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int off);
    logic [31:0] v;
    v = off;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'h63};
  endfunction

  // which: 0 forwarding instance, 1 interlock instance, 2 both
  task automatic exp_push(input int which, input int cyc, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.cyc = cyc; e.pc = pc; e.rd = rd; e.data = data;
    if (which != 1) q_f.push_back(e);
    if (which != 0) q_s.push_back(e);
  endtask

  task automatic load();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i < prog.size()) ? prog[i] : 32'h0;
      dut_f.m_imem.mem[i] = w;
      dut_s.m_imem.mem[i] = w;
    end
  endtask

  task automatic start();
    w_rst = 1'b1;
    @(posedge w_clk);
    load();
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  task automatic mon_one(input int k, input int cyc, input logic ret, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [31:0] data);
    exp_t  e;
    string s;
    s = (k == 0) ? "fwd" : "ilk";
    if (!ret || pc >= prog_end) return;
    if ((k == 0 && q_f.size() == 0) || (k == 1 && q_s.size() == 0)) begin
      check($sformatf("%s_extra_retire_c%0d_pc%0h", s, cyc, pc), 32'(ret), 32'd0);
      return;
    end
    e = (k == 0) ? q_f.pop_front() : q_s.pop_front();
    check($sformatf("%s_pc%0h_cycle", s, e.pc), cyc, e.cyc);
    check($sformatf("%s_pc%0h_pc", s, e.pc), pc, e.pc);
    check($sformatf("%s_pc%0h_rd", s, e.pc), 32'(rd), 32'(e.rd));
    check($sformatf("%s_pc%0h_data", s, e.pc), data, e.data);
  endtask

  task automatic run(input int n, input int rst_at);
    for (int c = 0; c < n; c++) begin
      mon_one(0, c, f_ret, f_pc, f_rd, f_data);
      mon_one(1, c, s_ret, s_pc, s_rd, s_data);
      check($sformatf("fwd_halt_c%0d", c), 32'(f_halt), 32'(c >= halt_cyc));
      check($sformatf("ilk_halt_c%0d", c), 32'(s_halt), 32'(c >= halt_cyc));
      if (c == rst_at) w_rst = 1'b1;
      @(posedge w_clk);
      @(negedge w_clk);
    end
    check("fwd_missing_retires", q_f.size(), 0);
    check("ilk_missing_retires", q_s.size(), 0);
    q_f.delete();
    q_s.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fwd_retire"}, 32'(f_ret), 0);
    check({tag, "_fwd_pc"}, f_pc, 0);
    check({tag, "_fwd_rd"}, 32'(f_rd), 0);
    check({tag, "_fwd_data"}, f_data, 0);
    check({tag, "_fwd_halt"}, 32'(f_halt), 0);
    check({tag, "_fwd_stall"}, 32'(f_stall), 0);
    check({tag, "_ilk_retire"}, 32'(s_ret), 0);
    check({tag, "_ilk_pc"}, s_pc, 0);
    check({tag, "_ilk_data"}, s_data, 0);
    check({tag, "_ilk_halt"}, 32'(s_halt), 0);
    check({tag, "_ilk_stall"}, 32'(s_stall), 0);
  endtask

  task automatic raw_chain_expect();
    exp_push(2, 3, 32'd0, 5'd1, 32'd3);
    exp_push(0, 4, 32'd4, 5'd2, 32'd7);
    exp_push(0, 5, 32'd8, 5'd3, 32'd12);
    exp_push(1, 5, 32'd4, 5'd2, 32'd7);
    exp_push(1, 7, 32'd8, 5'd3, 32'd12);
  endtask

  initial begin
    halt_cyc = 1000;

    // RAW chain
    prog = {enc_i(1, 0, 3), enc_i(2, 1, 4), enc_i(3, 2, 5)};
    prog_end = 32'd12;
    start();
    check_zero("reset");
    raw_chain_expect();
    run(12, -1);
    check("raw_fwd_stall_cnt", 32'(f_stall), 0);
    check("raw_ilk_stall_cnt", 32'(s_stall), 2);
    check("raw_fwd_x3", dut_f.rf[3], 12);
    check("raw_ilk_x3", dut_s.rf[3], 12);

    // ALU mix
    prog = {enc_i(1, 0, 'hF0), enc_i(2, 0, 'hFF), enc_i(9, 0, 'h123),
            enc_r('h20, 0, 3, 1, 2), enc_r(0, 7, 4, 1, 2), enc_r(0, 6, 5, 1, 2),
            enc_i(0, 0, 9), enc_r(0, 0, 6, 0, 0)};
    prog_end = 32'd32;
    start();
    exp_push(2, 3, 32'd0, 5'd1, 32'h0F0);
    exp_push(2, 4, 32'd4, 5'd2, 32'h0FF);
    exp_push(2, 5, 32'd8, 5'd9, 32'h123);
    exp_push(2, 6, 32'd12, 5'd3, 32'hFFFF_FFF1);
    exp_push(2, 7, 32'd16, 5'd4, 32'h0F0);
    exp_push(2, 8, 32'd20, 5'd5, 32'h0FF);
    exp_push(2, 9, 32'd24, 5'd0, 32'h0);
    exp_push(2, 10, 32'd28, 5'd6, 32'h0);
    run(14, -1);
    check("alu_ilk_stall_cnt", 32'(s_stall), 0);

    // Branch flush, then a not-taken beq
    prog = {enc_i(1, 0, 1), enc_i(9, 0, 5), enc_beq(1, 1, 12), enc_i(5, 0, 7),
            enc_i(6, 0, 8), enc_i(7, 0, 9), enc_beq(1, 0, 8), enc_i(10, 0, 11),
            enc_i(11, 0, 12)};
    prog_end = 32'd36;
    start();
    exp_push(2, 3, 32'd0, 5'd1, 32'd1);
    exp_push(2, 4, 32'd4, 5'd9, 32'd5);
    exp_push(2, 5, 32'd8, 5'd0, 32'd0);
    exp_push(2, 8, 32'd20, 5'd7, 32'd9);
    exp_push(2, 9, 32'd24, 5'd0, 32'd0);
    exp_push(2, 10, 32'd28, 5'd10, 32'd11);
    exp_push(2, 11, 32'd32, 5'd11, 32'd12);
    run(15, -1);
    check("br_fwd_x5", dut_f.rf[5], 0);
    check("br_ilk_x6", dut_s.rf[6], 0);

    // Halt: in-flight words (two NOPs after x8) drain, nothing retires afterwards
    prog = {enc_i(30, 0, 1), enc_i(8, 0, 2)};
    prog_end = 32'hFFFF_FFFF;
    halt_cyc = 4;
    start();
    exp_push(2, 3, 32'd0, 5'd30, 32'd1);
    exp_push(2, 4, 32'd4, 5'd8, 32'd2);
    exp_push(2, 5, 32'd8, 5'd0, 32'd0);
    exp_push(2, 6, 32'd12, 5'd0, 32'd0);
    run(16, -1);
    check("halt_fwd_x8", dut_f.rf[8], 2);
    halt_cyc = 1000;

    // Reset asserted during cycle 4 of the RAW chain
    prog = {enc_i(1, 0, 3), enc_i(2, 1, 4), enc_i(3, 2, 5)};
    prog_end = 32'd12;
    start();
    exp_push(2, 3, 32'd0, 5'd1, 32'd3);
    exp_push(0, 4, 32'd4, 5'd2, 32'd7);
    run(5, 4);
    check_zero("midrst");
    for (int r = 1; r <= 3; r++) begin
      check($sformatf("midrst_fwd_x%0d", r), dut_f.rf[r], 0);
      check($sformatf("midrst_ilk_x%0d", r), dut_s.rf[r], 0);
    end
    start();
    raw_chain_expect();
    run(12, -1);
    check("rerun_ilk_stall_cnt", 32'(s_stall), 2);
    check("rerun_fwd_x2", dut_f.rf[2], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
